load_store_queue: RTL and testbench

Parametrised successor to the single-channel load/store buffer: a circular in-order queue of memory micro-ops sitting between dispatch and the memory controller. Operands are captured from any of `CDB_N` common-data-bus channels. The memory side uses a req/done handshake with exactly one access outstanding. Loads are sign- or zero-extended before writeback. A flush with an access in flight is drained safely instead of being dropped.

---
 rtl/lsq_pkg.sv | 42 ++++
 rtl/lsq_load_ext.sv | 24 ++
 rtl/load_store_queue.sv | 230 +++++++++++++++++++++++
 tb/tb_load_store_queue.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_pkg.sv
// Shared types and constants for the load/store queue: entry layout, FSM states,
// RISC-V funct3 encodings and the immediate sign-extension helper.
package lsq_pkg;

    // The entry layout is fixed here, so the queue's TAG_W/XLEN must match these.
    localparam int LSQ_TAG_W = 4;
    localparam int LSQ_XLEN  = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } lsq_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 store;
        logic [2:0]           funct3;
        logic [LSQ_TAG_W-1:0] tag;
        logic [11:0]          imm;
        logic [LSQ_XLEN-1:0]  base;
        logic                 base_busy;
        logic [LSQ_TAG_W-1:0] base_q;
        logic [LSQ_XLEN-1:0]  data;
        logic                 data_busy;
        logic [LSQ_TAG_W-1:0] data_q;
    } lsq_entry_t;

    function automatic logic [LSQ_XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(LSQ_XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/lsq_load_ext.sv
// Load-result extension: sign- or zero-extends the raw right-justified memory
// data according to the access funct3.
module lsq_load_ext
    import lsq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){rdata_i[7]}}, rdata_i[7:0]};
            F3_LH:   data_o = {{(XLEN-16){rdata_i[15]}}, rdata_i[15:0]};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, rdata_i[7:0]};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, rdata_i[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_queue.sv
// Circular in-order load/store queue between dispatch and the memory controller,
// with multi-channel CDB operand capture and one outstanding memory access.
module load_store_queue
    import lsq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TAG_W = LSQ_TAG_W,
    parameter int XLEN  = LSQ_XLEN,
    parameter int CDB_N = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  in_valid,
    input  logic                  in_store,
    input  logic [2:0]            in_funct3,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic [11:0]           in_imm,
    input  logic [XLEN-1:0]       in_base,
    input  logic [XLEN-1:0]       in_data,
    input  logic                  in_base_busy,
    input  logic                  in_data_busy,
    input  logic [TAG_W-1:0]      in_base_q,
    input  logic [TAG_W-1:0]      in_data_q,
    output logic                  in_ready,
    input  logic [CDB_N-1:0]      cdb_valid,
    input  logic [CDB_N*TAG_W-1:0] cdb_tag,
    input  logic [CDB_N*XLEN-1:0] cdb_data,
    input  logic [TAG_W-1:0]      rob_head_tag,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [2:0]            mem_funct3,
    output logic [XLEN-1:0]       mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_done,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  wb_valid,
    output logic [TAG_W-1:0]      wb_tag,
    output logic [XLEN-1:0]       wb_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
    localparam logic [PTR_W-1:0] READY_LIMIT = PTR_W'(DEPTH - 2);

    lsq_entry_t       entries_q [DEPTH];
    lsq_entry_t       entries_d [DEPTH];
    lsq_entry_t       enq_entry;
    lsq_entry_t       head_e;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, count_d;
    lsq_state_e       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [2:0]       mem_funct3_q, mem_funct3_d;
    logic [XLEN-1:0]  mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic             wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d, ext_data;
    logic             empty, full, head_ready;

    assign empty  = (head_q == tail_q);
    assign full   = (head_q[PTR_W-1] != tail_q[PTR_W-1]) &&
                    (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);
    assign head_e = entries_q[head_q[IDX_W-1:0]];
    assign head_ready = !empty && head_e.valid && !head_e.base_busy &&
                        (!head_e.store || (!head_e.data_busy && rob_head_tag == head_e.tag));

    lsq_load_ext #(.XLEN(XLEN)) u_load_ext (
        .funct3_i (mem_funct3_q),
        .rdata_i  (mem_rdata),
        .data_o   (ext_data)
    );

    // Channels are scanned from the highest index down so the lowest matching channel wins.
    always_comb begin
        entries_d    = entries_q;
        head_d       = head_q;
        tail_d       = tail_q;
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_funct3_d = mem_funct3_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        wb_valid_d   = wb_valid_q;
        wb_tag_d     = wb_tag_q;
        wb_data_d    = wb_data_q;
        enq_entry    = '0;
        count_d      = '0;
        if (rdy) begin
            wb_valid_d = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (entries_q[i].valid) begin
                    for (int k = CDB_N - 1; k >= 0; k--) begin
                        if (cdb_valid[k] && entries_q[i].base_busy &&
                            cdb_tag[k*TAG_W +: TAG_W] == entries_q[i].base_q) begin
                            entries_d[i].base      = cdb_data[k*XLEN +: XLEN];
                            entries_d[i].base_busy = 1'b0;
                        end
                        if (cdb_valid[k] && entries_q[i].data_busy &&
                            cdb_tag[k*TAG_W +: TAG_W] == entries_q[i].data_q) begin
                            entries_d[i].data      = cdb_data[k*XLEN +: XLEN];
                            entries_d[i].data_busy = 1'b0;
                        end
                    end
                end
            end

            case (state_q)
                IDLE: begin
                    if (head_ready) begin
                        state_d      = WAIT;
                        mem_req_d    = 1'b1;
                        mem_we_d     = head_e.store;
                        mem_funct3_d = head_e.funct3;
                        mem_addr_d   = head_e.base + sext12(head_e.imm);
                        mem_wdata_d  = head_e.data;
                    end
                end
                WAIT: begin
                    if (mem_done) begin
                        state_d    = IDLE;
                        mem_req_d  = 1'b0;
                        head_d     = head_q + PTR_ONE;
                        entries_d[head_q[IDX_W-1:0]].valid = 1'b0;
                        wb_valid_d = 1'b1;
                        wb_tag_d   = head_e.tag;
                        wb_data_d  = head_e.store ? '0 : ext_data;
                    end else if (flush) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_done) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (in_valid && !full) begin
                enq_entry.valid     = 1'b1;
                enq_entry.store     = in_store;
                enq_entry.funct3    = in_funct3;
                enq_entry.tag       = in_tag;
                enq_entry.imm       = in_imm;
                enq_entry.base      = in_base;
                enq_entry.base_busy = in_base_busy;
                enq_entry.base_q    = in_base_q;
                enq_entry.data      = in_data;
                enq_entry.data_busy = in_data_busy;
                enq_entry.data_q    = in_data_q;
                for (int k = CDB_N - 1; k >= 0; k--) begin
                    if (cdb_valid[k] && in_base_busy && cdb_tag[k*TAG_W +: TAG_W] == in_base_q) begin
                        enq_entry.base      = cdb_data[k*XLEN +: XLEN];
                        enq_entry.base_busy = 1'b0;
                    end
                    if (cdb_valid[k] && in_data_busy && cdb_tag[k*TAG_W +: TAG_W] == in_data_q) begin
                        enq_entry.data      = cdb_data[k*XLEN +: XLEN];
                        enq_entry.data_busy = 1'b0;
                    end
                end
                entries_d[tail_q[IDX_W-1:0]] = enq_entry;
                tail_d = tail_q + PTR_ONE;
            end

            // A flush wins over enqueue and hides any completion landing on this edge.
            if (flush) begin
                head_d     = '0;
                tail_d     = '0;
                wb_valid_d = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    entries_d[i].valid = 1'b0;
                end
            end

            count_d    = tail_d - head_d;
            in_ready_d = (count_d <= READY_LIMIT) && (state_d != DRAIN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_funct3_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_tag_q     <= '0;
            wb_data_q    <= '0;
        end else begin
            entries_q    <= entries_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_funct3_q <= mem_funct3_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_tag_q     <= wb_tag_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_funct3 = mem_funct3_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_tag     = wb_tag_q;
    assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_load_store_queue.sv
// Self-checking bench for load_store_queue: a vector table of single accesses,
// hand-written multi-cycle sequences, and a writeback scoreboard.
module tb_load_store_queue;
    import lsq_pkg::*;

    localparam int DEPTH = 16;
    localparam int TAG_W = 4;
    localparam int XLEN  = 32;
    localparam int CDB_N = 2;

    logic                   clk = 1'b0;
    logic                   rst, rdy;
    logic                   in_valid, in_store, in_base_busy, in_data_busy;
    logic [2:0]             in_funct3;
    logic [TAG_W-1:0]       in_tag, in_base_q, in_data_q, rob_head_tag;
    logic [11:0]            in_imm;
    logic [XLEN-1:0]        in_base, in_data;
    logic                   in_ready;
    logic [CDB_N-1:0]       cdb_valid;
    logic [CDB_N*TAG_W-1:0] cdb_tag;
    logic [CDB_N*XLEN-1:0]  cdb_data;
    logic                   flush;
    logic                   mem_req, mem_we, mem_done;
    logic [2:0]             mem_funct3;
    logic [XLEN-1:0]        mem_addr, mem_wdata, mem_rdata;
    logic                   wb_valid;
    logic [TAG_W-1:0]       wb_tag;
    logic [XLEN-1:0]        wb_data;

    always #5 clk = ~clk;

    load_store_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .CDB_N(CDB_N)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_valid(in_valid), .in_store(in_store), .in_funct3(in_funct3), .in_tag(in_tag),
        .in_imm(in_imm), .in_base(in_base), .in_data(in_data),
        .in_base_busy(in_base_busy), .in_data_busy(in_data_busy),
        .in_base_q(in_base_q), .in_data_q(in_data_q), .in_ready(in_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rob_head_tag(rob_head_tag), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
    } wb_exp_t;

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [3:0]  tag;
        logic [11:0] imm;
        logic [31:0] base;
        logic [31:0] data;
        logic [31:0] rdata;
        logic [31:0] expAddr;
        logic [31:0] expWb;
    } vec_t;

    wb_exp_t expQ[$];
    vec_t    vecs[9];
    int      checks   = 0;
    int      failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin : wbMonitor
        wb_exp_t e;
        if (!rst && wb_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL wb_unexpected: got wb_valid tag=%0d data=0x%08h with nothing expected", wb_tag, wb_data);
            end else begin
                e = expQ.pop_front();
                checkOutput("wb_tag", 32'(wb_tag), 32'(e.tag));
                checkOutput("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic applyStimulus(input logic store, input logic [2:0] f3, input logic [3:0] tag,
                                 input logic [11:0] imm, input logic [31:0] base, input logic [31:0] data,
                                 input logic baseBusy, input logic [3:0] baseQ,
                                 input bit expectWb, input logic [31:0] expWb);
        wb_exp_t e;
        checkOutput("enq_in_ready", 32'(in_ready), 32'd1);
        in_valid     = 1'b1;
        in_store     = store;
        in_funct3    = f3;
        in_tag       = tag;
        in_imm       = imm;
        in_base      = base;
        in_data      = data;
        in_base_busy = baseBusy;
        in_base_q    = baseQ;
        in_data_busy = 1'b0;
        in_data_q    = '0;
        if (expectWb) begin
            e.tag  = tag;
            e.data = expWb;
            expQ.push_back(e);
        end
        @(negedge clk);
        in_valid     = 1'b0;
        in_base_busy = 1'b0;
    endtask

    task automatic waitReq(input string name, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: mem_req still low after 40 cycles, required high", name);
        end
    endtask

    task automatic serviceRequest(input string name, input logic [31:0] expAddr, input logic expWe,
                                  input logic [2:0] expF3, input logic [31:0] expWdata,
                                  input logic [31:0] rdata);
        bit ok;
        waitReq(name, ok);
        if (ok) begin
            checkOutput({name, "_addr"}, mem_addr, expAddr);
            checkOutput({name, "_we"}, 32'(mem_we), 32'(expWe));
            checkOutput({name, "_f3"}, 32'(mem_funct3), 32'(expF3));
            if (expWe) checkOutput({name, "_wdata"}, mem_wdata, expWdata);
            mem_done  = 1'b1;
            mem_rdata = rdata;
            @(negedge clk);
            mem_done  = 1'b0;
            mem_rdata = '0;
        end
    endtask

    task automatic expectNoReq(input string name, input int cycles);
        bit seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (mem_req) seen = 1'b1;
            @(negedge clk);
        end
        checkOutput(name, 32'(seen), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        bit ok;
        int pushed;
        rst = 1'b1; rdy = 1'b1; in_valid = 1'b0; in_store = 1'b0; in_funct3 = '0; in_tag = '0;
        in_imm = '0; in_base = '0; in_data = '0; in_base_busy = 1'b0; in_data_busy = 1'b0;
        in_base_q = '0; in_data_q = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        rob_head_tag = '0; flush = 1'b0; mem_done = 1'b0; mem_rdata = '0;

        vecs[0] = '{1'b0, F3_LW,  4'd3,  12'hFFC, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 32'h0000_00FC, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, F3_LB,  4'd1,  12'h010, 32'h0000_1000, 32'h0, 32'h0000_0080, 32'h0000_1010, 32'hFFFF_FF80};
        vecs[2] = '{1'b0, F3_LBU, 4'd2,  12'h000, 32'h0000_1000, 32'h0, 32'h0000_0080, 32'h0000_1000, 32'h0000_0080};
        vecs[3] = '{1'b0, F3_LH,  4'd4,  12'h020, 32'hFFFF_FFF0, 32'h0, 32'h0000_8001, 32'h0000_0010, 32'hFFFF_8001};
        vecs[4] = '{1'b0, F3_LHU, 4'd6,  12'h002, 32'h0000_0200, 32'h0, 32'h1234_8001, 32'h0000_0202, 32'h0000_8001};
        vecs[5] = '{1'b0, F3_LB,  4'd8,  12'h001, 32'h0000_0300, 32'h0, 32'hFFFF_FF7F, 32'h0000_0301, 32'h0000_007F};
        vecs[6] = '{1'b1, F3_SW,  4'd9,  12'h7FF, 32'h0000_2000, 32'hCAFE_F00D, 32'h0, 32'h0000_27FF, 32'h0};
        vecs[7] = '{1'b1, F3_SB,  4'd10, 12'h800, 32'h0000_0300, 32'h0000_0055, 32'h0, 32'hFFFF_FB00, 32'h0};
        vecs[8] = '{1'b0, F3_LW,  4'd15, 12'h7FF, 32'h0000_0000, 32'h0, 32'h0123_4567, 32'h0000_07FF, 32'h0123_4567};

        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready",   32'(in_ready),   32'd1);
        checkOutput("rst_mem_req",    32'(mem_req),    32'd0);
        checkOutput("rst_mem_we",     32'(mem_we),     32'd0);
        checkOutput("rst_mem_funct3", 32'(mem_funct3), 32'd0);
        checkOutput("rst_mem_addr",   mem_addr,        32'd0);
        checkOutput("rst_mem_wdata",  mem_wdata,       32'd0);
        checkOutput("rst_wb_valid",   32'(wb_valid),   32'd0);
        checkOutput("rst_wb_tag",     32'(wb_tag),     32'd0);
        checkOutput("rst_wb_data",    wb_data,         32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].store) rob_head_tag = vecs[i].tag;
            applyStimulus(vecs[i].store, vecs[i].f3, vecs[i].tag, vecs[i].imm, vecs[i].base,
                          vecs[i].data, 1'b0, 4'd0, 1'b1, vecs[i].expWb);
            serviceRequest($sformatf("vec%0d", i), vecs[i].expAddr, vecs[i].store, vecs[i].f3,
                           vecs[i].data, vecs[i].rdata);
        end

        // Store waits for the ROB head, then commits.
        rob_head_tag = 4'd4;
        applyStimulus(1'b1, F3_SW, 4'd5, 12'h008, 32'h0000_4000, 32'h1234_5678, 1'b0, 4'd0, 1'b1, 32'h0);
        expectNoReq("store_gated", 6);
        rob_head_tag = 4'd5;
        serviceRequest("store_commit", 32'h0000_4008, 1'b1, F3_SW, 32'h1234_5678, 32'h0);

        // With rdy low, mem_done and an enqueue are both ignored.
        applyStimulus(1'b0, F3_LW, 4'd0, 12'h000, 32'h0000_0040, 32'h0, 1'b0, 4'd0, 1'b1, 32'hA5A5_0000);
        waitReq("rdy_req", ok);
        rdy = 1'b0; mem_done = 1'b1; mem_rdata = 32'h1111_1111;
        in_valid = 1'b1; in_store = 1'b0; in_funct3 = F3_LW; in_tag = 4'd9; in_base = 32'h80;
        @(negedge clk);
        mem_done = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rdy_hold_req",  32'(mem_req),  32'd1);
        checkOutput("rdy_hold_wb",   32'(wb_valid), 32'd0);
        checkOutput("rdy_hold_addr", mem_addr,      32'h0000_0040);
        rdy = 1'b1;
        serviceRequest("rdy_resume", 32'h0000_0040, 1'b0, F3_LW, 32'h0, 32'hA5A5_0000);
        expectNoReq("rdy_enq_dropped", 4);

        // Base captured from CDB channel 1 after enqueue.
        applyStimulus(1'b0, F3_LW, 4'd11, 12'h000, 32'hBAD0_0000, 32'h0, 1'b1, 4'd7, 1'b1, 32'h0BAD_F00D);
        expectNoReq("cdb_pending", 4);
        cdb_valid = 2'b11; cdb_tag = {4'd7, 4'd2}; cdb_data = {32'h0000_0200, 32'hFFFF_0000};
        @(negedge clk);
        cdb_valid = '0;
        checkOutput("cdb_capture_no_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        checkOutput("cdb_issue_latency", 32'(mem_req), 32'd1);
        serviceRequest("cdb_capture", 32'h0000_0200, 1'b0, F3_LW, 32'h0, 32'h0BAD_F00D);

        // Same-cycle bypass; both channels match, channel 0 must win.
        cdb_valid = 2'b11; cdb_tag = {4'd7, 4'd7}; cdb_data = {32'h0000_0500, 32'h0000_0400};
        applyStimulus(1'b0, F3_LW, 4'd12, 12'h004, 32'h0000_0BAD, 32'h0, 1'b1, 4'd7, 1'b1, 32'h0000_0077);
        cdb_valid = '0;
        checkOutput("enq_latency_no_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        checkOutput("enq_latency_req", 32'(mem_req), 32'd1);
        serviceRequest("cdb_bypass", 32'h0000_0404, 1'b0, F3_LW, 32'h0, 32'h0000_0077);

        // Fill with the head access held outstanding, then drain.
        pushed = 0;
        for (int i = 0; i < 20; i++) begin
            if (!in_ready) break;
            applyStimulus(1'b0, F3_LW, 4'(i), 12'h000, 32'(i * 4), 32'h0, 1'b0, 4'd0, 1'b1, 32'h1000 + 32'(i));
            pushed++;
        end
        checkOutput("fill_count", 32'(pushed), 32'd15);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 15; i++) begin
            serviceRequest($sformatf("drain%0d", i), 32'(i * 4), 1'b0, F3_LW, 32'h0, 32'h1000 + 32'(i));
        end

        // Twenty more in pairs so both pointers wrap.
        for (int i = 0; i < 20; i += 2) begin
            applyStimulus(1'b0, F3_LW, 4'(i), 12'h010, 32'h8000 + 32'(i * 8), 32'h0, 1'b0, 4'd0, 1'b1, 32'hC000 + 32'(i));
            applyStimulus(1'b0, F3_LW, 4'(i + 1), 12'h010, 32'h8000 + 32'((i + 1) * 8), 32'h0, 1'b0, 4'd0, 1'b1, 32'hC000 + 32'(i + 1));
            serviceRequest($sformatf("wrap%0d", i), 32'h8010 + 32'(i * 8), 1'b0, F3_LW, 32'h0, 32'hC000 + 32'(i));
            serviceRequest($sformatf("wrap%0d", i + 1), 32'h8010 + 32'((i + 1) * 8), 1'b0, F3_LW, 32'h0, 32'hC000 + 32'(i + 1));
        end

        // Flush with a load outstanding: drain, no writeback, empty queue afterwards.
        applyStimulus(1'b0, F3_LW, 4'd13, 12'h000, 32'h0000_0500, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0);
        waitReq("flush_req", ok);
        applyStimulus(1'b0, F3_LW, 4'd14, 12'h000, 32'h0000_0540, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0);
        flush = 1'b1;
        in_valid = 1'b1; in_store = 1'b0; in_funct3 = F3_LW; in_tag = 4'd10; in_base = 32'h580;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checkOutput("drain_in_ready", 32'(in_ready), 32'd0);
        checkOutput("drain_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("drain_hold_req", 32'(mem_req), 32'd1);
        mem_done = 1'b1; mem_rdata = 32'h0000_FFFF;
        @(negedge clk);
        mem_done = 1'b0;
        checkOutput("drain_done_req", 32'(mem_req), 32'd0);
        checkOutput("drain_done_in_ready", 32'(in_ready), 32'd1);
        expectNoReq("flush_empty", 5);
        applyStimulus(1'b0, F3_LW, 4'd1, 12'h000, 32'h0000_0600, 32'h0, 1'b0, 4'd0, 1'b1, 32'h0006_00AB);
        serviceRequest("after_flush", 32'h0000_0600, 1'b0, F3_LW, 32'h0, 32'h0006_00AB);

        @(negedge clk);
        @(negedge clk);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        checkOutput("final_mem_req", 32'(mem_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
